// File: rtl/arp_rx_multi.sv
// GMII-side ARP receiver: preamble/Ethernet/ARP parse, multi-IP target match, gratuitous/conflict detect.
// Optional 802.1Q single-tag support when ARP_RX_VLAN_EN is defined.
module arp_rx_multi #(
  parameter logic [47:0]          BOARD_MAC     = 48'h00_11_22_33_44_55,
  parameter int                   NUM_IP        = 4,
  parameter logic [32*NUM_IP-1:0] BOARD_IP_LIST = {NUM_IP{8'd192, 8'd168, 8'd1, 8'd10}},
  parameter bit                   CHECK_HDR     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        arp_rx_done,
  output logic        arp_rx_type,
  output logic        arp_rx_grat,
  output logic        arp_ip_conflict,
  output logic [3:0]  ip_hit_idx,
  output logic [47:0] src_mac,
  output logic [31:0] src_ip,
  output logic [15:0] drop_cnt,
  output logic [2:0]  state_dbg
);

`ifdef ARP_RX_VLAN_EN
  localparam bit VLAN_EN = 1'b1;
`else
  localparam bit VLAN_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    ETH_HEAD = 3'd2,
    VLAN     = 3'd3,
    ARP_DATA = 3'd4,
    RX_END   = 3'd5
  } state_t;

  state_t      state, state_n;
  logic [4:0]  cnt;
  logic [39:0] sh;
  logic        hdr_ok, hdr_ok_n;
  logic [15:0] oper_q;
  logic [47:0] sha_q;
  logic [31:0] spa_q;
  logic [23:0] tpa_q;
  logic [7:0]  hdr_exp;
  logic [47:0] da;
  logic [15:0] etype;
  logic [31:0] tpa_full;
  logic        tpa_hit, spa_hit, grat, oper_ok, accept, last_byte, drop_evt;
  logic [3:0]  tpa_idx, spa_idx;

  assign state_dbg = state;
  // sh holds the most recent bytes, so a field is complete the cycle its last byte arrives
  assign da        = {sh, gmii_rxd};
  assign etype     = {sh[7:0], gmii_rxd};
  assign tpa_full  = {tpa_q, gmii_rxd};
  assign grat      = (spa_q == tpa_full);
  assign oper_ok   = (oper_q == 16'd1) || (oper_q == 16'd2);
  assign accept    = (hdr_ok || !CHECK_HDR) && oper_ok && (tpa_hit || grat);
  assign last_byte = (state == ARP_DATA) && gmii_rx_dv && (cnt == 5'd27);
  assign drop_evt  = (last_byte && !accept) || ((state == ARP_DATA) && !gmii_rx_dv);

  always_comb begin
    hdr_exp = 8'h00;
    case (cnt)
      5'd1:    hdr_exp = 8'h01;
      5'd2:    hdr_exp = 8'h08;
      5'd4:    hdr_exp = 8'h06;
      5'd5:    hdr_exp = 8'h04;
      default: hdr_exp = 8'h00;
    endcase
    hdr_ok_n = ((cnt == 5'd0) ? 1'b1 : hdr_ok) && (gmii_rxd == hdr_exp);
  end

  // Descending scan so the lowest matching index is the one left standing
  always_comb begin
    tpa_hit = 1'b0;
    tpa_idx = 4'd0;
    spa_hit = 1'b0;
    spa_idx = 4'd0;
    for (int i = NUM_IP - 1; i >= 0; i--) begin
      if (BOARD_IP_LIST[32*i +: 32] == tpa_full) begin
        tpa_hit = 1'b1;
        tpa_idx = 4'(i);
      end
      if (BOARD_IP_LIST[32*i +: 32] == spa_q) begin
        spa_hit = 1'b1;
        spa_idx = 4'(i);
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:
        if (gmii_rx_dv && gmii_rxd == 8'h55) state_n = PREAMBLE;
      PREAMBLE:
        if (!gmii_rx_dv)                             state_n = IDLE;
        else if (gmii_rxd == 8'hD5)                  state_n = ETH_HEAD;
        else if (gmii_rxd == 8'h55 && cnt <= 5'd5)   state_n = PREAMBLE;
        else                                         state_n = RX_END;
      ETH_HEAD:
        if (!gmii_rx_dv) state_n = IDLE;
        else if (cnt == 5'd5 && da != BOARD_MAC && da != 48'hFFFF_FFFF_FFFF) state_n = RX_END;
        else if (cnt == 5'd13) begin
          if (etype == 16'h0806)                  state_n = ARP_DATA;
          else if (VLAN_EN && etype == 16'h8100)  state_n = VLAN;
          else                                    state_n = RX_END;
        end
      VLAN:
        if (!gmii_rx_dv) state_n = IDLE;
        else if (cnt == 5'd3) state_n = (etype == 16'h0806) ? ARP_DATA : RX_END;
      ARP_DATA:
        if (!gmii_rx_dv)        state_n = IDLE;
        else if (cnt == 5'd27)  state_n = RX_END;
      RX_END:
        if (!gmii_rx_dv) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RX_END;
      cnt   <= 5'd0;
    end else begin
      state <= state_n;
      if (state_n != state)
        cnt <= 5'd0;
      else if (gmii_rx_dv && (state == PREAMBLE || state == ETH_HEAD ||
                              state == VLAN || state == ARP_DATA))
        cnt <= cnt + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh              <= '0;
      hdr_ok          <= 1'b0;
      oper_q          <= '0;
      sha_q           <= '0;
      spa_q           <= '0;
      tpa_q           <= '0;
      arp_rx_done     <= 1'b0;
      arp_rx_type     <= 1'b0;
      arp_rx_grat     <= 1'b0;
      arp_ip_conflict <= 1'b0;
      ip_hit_idx      <= 4'd0;
      src_mac         <= '0;
      src_ip          <= '0;
      drop_cnt        <= '0;
    end else begin
      arp_rx_done     <= 1'b0;
      arp_ip_conflict <= 1'b0;
      if (gmii_rx_dv) sh <= {sh[31:0], gmii_rxd};
      if (state == ARP_DATA && gmii_rx_dv) begin
        if (cnt <= 5'd5)                  hdr_ok <= hdr_ok_n;
        if (cnt == 5'd6 || cnt == 5'd7)   oper_q <= {oper_q[7:0], gmii_rxd};
        if (cnt >= 5'd8 && cnt <= 5'd13)  sha_q  <= {sha_q[39:0], gmii_rxd};
        if (cnt >= 5'd14 && cnt <= 5'd17) spa_q  <= {spa_q[23:0], gmii_rxd};
        if (cnt >= 5'd24 && cnt <= 5'd26) tpa_q  <= {tpa_q[15:0], gmii_rxd};
      end
      if (last_byte && accept) begin
        arp_rx_done     <= 1'b1;
        arp_rx_type     <= oper_q[1];
        arp_rx_grat     <= grat;
        arp_ip_conflict <= grat && spa_hit;
        ip_hit_idx      <= grat ? (spa_hit ? spa_idx : 4'd0) : tpa_idx;
        src_mac         <= sha_q;
        src_ip          <= spa_q;
      end
      if (drop_evt && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_arp_rx_multi.sv
// Directed bench for arp_rx_multi: hand-built frames, expected-sender-IP scoreboard, per-frame checks.
module tb_arp_rx_multi;
  localparam logic [47:0] MAC   = 48'h00_11_22_33_44_55;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [31:0] E0 = 32'hC0A8010A, E1 = 32'hC0A8010B, E2 = 32'hC0A8010C, E3 = 32'hC0A8010D;

  logic        clk = 1'b0;
  logic        rst, dv;
  logic [7:0]  rxd;
  logic        arp_rx_done, arp_rx_type, arp_rx_grat, arp_ip_conflict;
  logic [3:0]  ip_hit_idx;
  logic [47:0] src_mac;
  logic [31:0] src_ip;
  logic [15:0] drop_cnt;
  logic [2:0]  state_dbg;

  int          checks = 0, failures = 0;
  int          exp_drop = 0;
  int          mark_idx = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  tx_q[$];
  logic        s_pre, s_done, s_conf;

  arp_rx_multi #(
    .BOARD_MAC    (MAC),
    .NUM_IP       (4),
    .BOARD_IP_LIST({E3, E2, E1, E0}),
    .CHECK_HDR    (1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .gmii_rx_dv     (dv),
    .gmii_rxd       (rxd),
    .arp_rx_done    (arp_rx_done),
    .arp_rx_type    (arp_rx_type),
    .arp_rx_grat    (arp_rx_grat),
    .arp_ip_conflict(arp_ip_conflict),
    .ip_hit_idx     (ip_hit_idx),
    .src_mac        (src_mac),
    .src_ip         (src_ip),
    .drop_cnt       (drop_cnt),
    .state_dbg      (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the next expected sender IP
  always @(negedge clk) begin
    if (!rst && arp_rx_done === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_done", {63'd0, arp_rx_done}, 64'd0);
      else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("sb_src_ip", {32'd0, src_ip}, e);
      end
    end
  end

  initial begin
    #2_000_000;
    checks++;
    failures++;
    $display("FAIL timeout: simulation bound expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic build(input int npre, input logic [47:0] da, input bit vlan,
                       input logic [15:0] etype, input logic [15:0] htype, input logic [15:0] oper,
                       input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa);
    logic [47:0] sa;
    sa = 48'h02_00_00_00_00_09;
    tx_q.delete();
    repeat (npre) tx_q.push_back(8'h55);
    tx_q.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) tx_q.push_back(da[8*i +: 8]);
    for (int i = 5; i >= 0; i--) tx_q.push_back(sa[8*i +: 8]);
    if (vlan) begin
      tx_q.push_back(8'h81); tx_q.push_back(8'h00);
      tx_q.push_back(8'h00); tx_q.push_back(8'h05);
    end
    tx_q.push_back(etype[15:8]); tx_q.push_back(etype[7:0]);
    tx_q.push_back(htype[15:8]); tx_q.push_back(htype[7:0]);
    tx_q.push_back(8'h08); tx_q.push_back(8'h00);
    tx_q.push_back(8'h06); tx_q.push_back(8'h04);
    tx_q.push_back(oper[15:8]); tx_q.push_back(oper[7:0]);
    for (int i = 5; i >= 0; i--) tx_q.push_back(sha[8*i +: 8]);
    for (int i = 3; i >= 0; i--) tx_q.push_back(spa[8*i +: 8]);
    repeat (6) tx_q.push_back(8'h00);
    for (int i = 3; i >= 0; i--) tx_q.push_back(tpa[8*i +: 8]);
    mark_idx = tx_q.size() - 1;
    repeat (4) tx_q.push_back(8'hA5);
  endtask

  // Drives tx_q (first n bytes when cut >= 0); pulses rst while byte rst_at is on the wire
  task automatic send(input int cut, input int rst_at);
    int n;
    n = (cut < 0) ? tx_q.size() : cut;
    s_pre = 1'b0; s_done = 1'b0; s_conf = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == mark_idx) s_pre = arp_rx_done;
      if (i == mark_idx + 1) begin
        s_done = arp_rx_done;
        s_conf = arp_ip_conflict;
      end
      rst = (i == rst_at);
      dv  = 1'b1;
      rxd = tx_q[i];
    end
    @(negedge clk);
    rst = 1'b0; dv = 1'b0; rxd = 8'h00;
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_accept(input string t, input logic typ, input logic gr, input logic conf,
                            input logic [3:0] idx, input logic [47:0] mac, input logic [31:0] ip);
    check({t, "_pre"},  {63'd0, s_pre}, 64'd0);
    check({t, "_done"}, {63'd0, s_done}, 64'd1);
    check({t, "_conf"}, {63'd0, s_conf}, {63'd0, conf});
    check({t, "_type"}, {63'd0, arp_rx_type}, {63'd0, typ});
    check({t, "_grat"}, {63'd0, arp_rx_grat}, {63'd0, gr});
    check({t, "_idx"},  {60'd0, ip_hit_idx}, {60'd0, idx});
    check({t, "_mac"},  {16'd0, src_mac}, {16'd0, mac});
    check({t, "_ip"},   {32'd0, src_ip}, {32'd0, ip});
    check({t, "_drop"}, {48'd0, drop_cnt}, 64'(exp_drop));
  endtask

  task automatic chk_reject(input string t);
    check({t, "_done"}, {63'd0, s_done}, 64'd0);
    check({t, "_drop"}, {48'd0, drop_cnt}, 64'(exp_drop));
  endtask

  initial begin
    rst = 1'b1; dv = 1'b0; rxd = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_done", {63'd0, arp_rx_done}, 64'd0);
    check("rst_type", {63'd0, arp_rx_type}, 64'd0);
    check("rst_grat", {63'd0, arp_rx_grat}, 64'd0);
    check("rst_conf", {63'd0, arp_ip_conflict}, 64'd0);
    check("rst_idx",  {60'd0, ip_hit_idx}, 64'd0);
    check("rst_mac",  {16'd0, src_mac}, 64'd0);
    check("rst_ip",   {32'd0, src_ip}, 64'd0);
    check("rst_drop", {48'd0, drop_cnt}, 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Broadcast request, TPA = entry 2
    build(7, BCAST, 0, 16'h0806, 16'h0001, 16'd1, 48'h02AABBCCDD01, 32'hC0A80102, E2);
    exp_q.push_back({32'd0, 32'hC0A80102});
    send(-1, -1);
    chk_accept("t1", 0, 0, 0, 4'd2, 48'h02AABBCCDD01, 32'hC0A80102);

    // Unicast reply, TPA = entry 0
    build(7, MAC, 0, 16'h0806, 16'h0001, 16'd2, 48'h020000000077, 32'hC0A80105, E0);
    exp_q.push_back({32'd0, 32'hC0A80105});
    send(-1, -1);
    chk_accept("t2", 1, 0, 0, 4'd0, 48'h020000000077, 32'hC0A80105);

    // TPA misses the table
    build(7, BCAST, 0, 16'h0806, 16'h0001, 16'd1, 48'h020000000001, 32'hC0A80102, 32'hC0A80163);
    exp_drop = 1;
    send(-1, -1);
    chk_reject("t3_miss");
    check("t3_hold_ip", {32'd0, src_ip}, {32'd0, 32'hC0A80105});

    // Unsupported OPER
    build(7, BCAST, 0, 16'h0806, 16'h0001, 16'd3, 48'h020000000001, 32'hC0A80102, E0);
    exp_drop = 2;
    send(-1, -1);
    chk_reject("t3_oper");

    // Gratuitous, SPA = TPA = entry 1 -> conflict
    build(7, BCAST, 0, 16'h0806, 16'h0001, 16'd1, 48'h020000000044, E1, E1);
    exp_q.push_back({32'd0, E1});
    send(-1, -1);
    chk_accept("t4_conf", 0, 1, 1, 4'd1, 48'h020000000044, E1);

    // Gratuitous, foreign address -> no conflict
    build(7, BCAST, 0, 16'h0806, 16'h0001, 16'd2, 48'h020000000055, 32'h0A000005, 32'h0A000005);
    exp_q.push_back({32'd0, 32'h0A000005});
    send(-1, -1);
    chk_accept("t4_grat", 1, 1, 0, 4'd0, 48'h020000000055, 32'h0A000005);

    // Bad HTYPE
    build(7, BCAST, 0, 16'h0806, 16'h0002, 16'd1, 48'h020000000001, 32'hC0A80102, E0);
    exp_drop = 3;
    send(-1, -1);
    chk_reject("t_htype");

    // dv drops at ARP byte 10
    build(7, BCAST, 0, 16'h0806, 16'h0001, 16'd1, 48'h020000000001, 32'hC0A80102, E0);
    exp_drop = 4;
    send(8 + 14 + 10, -1);
    chk_reject("t5_trunc");

    build(7, BCAST, 0, 16'h0806, 16'h0001, 16'd1, 48'h020000000066, 32'hC0A80107, E3);
    exp_q.push_back({32'd0, 32'hC0A80107});
    send(-1, -1);
    chk_accept("t5_next", 0, 0, 0, 4'd3, 48'h020000000066, 32'hC0A80107);

    // Foreign DA, over-long preamble, non-ARP ethertype: silent
    build(7, 48'h001122334456, 0, 16'h0806, 16'h0001, 16'd1, 48'h020000000001, 32'hC0A80102, E0);
    send(-1, -1);
    chk_reject("t_da");
    build(8, BCAST, 0, 16'h0806, 16'h0001, 16'd1, 48'h020000000001, 32'hC0A80102, E0);
    send(-1, -1);
    chk_reject("t_pre8");
    build(7, BCAST, 0, 16'h0800, 16'h0001, 16'd1, 48'h020000000001, 32'hC0A80102, E0);
    send(-1, -1);
    chk_reject("t_etype");

    // Single preamble byte is enough
    build(1, BCAST, 0, 16'h0806, 16'h0001, 16'd1, 48'h020000000088, 32'hC0A80108, E2);
    exp_q.push_back({32'd0, 32'hC0A80108});
    send(-1, -1);
    chk_accept("t_pre1", 0, 0, 0, 4'd2, 48'h020000000088, 32'hC0A80108);

    // 802.1Q tagged request
    build(7, BCAST, 1, 16'h0806, 16'h0001, 16'd1, 48'h020000000099, 32'hC0A80106, E0);
`ifdef ARP_RX_VLAN_EN
    exp_q.push_back({32'd0, 32'hC0A80106});
    send(-1, -1);
    chk_accept("t6_vlan", 0, 0, 0, 4'd0, 48'h020000000099, 32'hC0A80106);
`else
    send(-1, -1);
    chk_reject("t6_vlan");
`endif

    // Reset mid-frame with dv held: everything back to zero, rest of frame ignored
    build(7, BCAST, 0, 16'h0806, 16'h0001, 16'd1, 48'h0200000000AA, 32'hC0A80104, E0);
    exp_drop = 0;
    send(-1, 8 + 14 + 15);
    chk_reject("t5_rst");
    check("t5_rst_ip",  {32'd0, src_ip}, 64'd0);
    check("t5_rst_mac", {16'd0, src_mac}, 64'd0);
    check("t5_rst_idx", {60'd0, ip_hit_idx}, 64'd0);
    check("t5_rst_type", {63'd0, arp_rx_type}, 64'd0);

    build(7, BCAST, 0, 16'h0806, 16'h0001, 16'd1, 48'h0200000000BB, 32'hC0A80109, E1);
    exp_q.push_back({32'd0, 32'hC0A80109});
    send(-1, -1);
    chk_accept("t5_recover", 0, 0, 0, 4'd1, 48'h0200000000BB, 32'hC0A80109);

    repeat (4) @(negedge clk);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
